// File: rtl/gpio_sync_pkg.sv
// gpio_sync_pkg: shared defaults and counter-width helper for gpio_sync_filter
package gpio_sync_pkg;
  localparam int DEF_STAGES      = 2;
  localparam int DEF_FILT_CYCLES = 4;
  function automatic int cnt_width(input int filt_cycles);
    return $clog2(filt_cycles + 1);
  endfunction
endpackage

// File: rtl/gpio_sync_filter_ch.sv
// gpio_sync_filter_ch: one channel -- plain synchroniser chain, stability counter, edge pulses
module gpio_sync_filter_ch
  import gpio_sync_pkg::*;
#(
  parameter int   STAGES      = DEF_STAGES,
  parameter int   FILT_CYCLES = DEF_FILT_CYCLES,
  parameter logic INIT        = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  input  logic i_en,
  output logic o_d,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = cnt_width(FILT_CYCLES);
  logic [STAGES-1:0] r_sync;
  logic [CW-1:0]     r_cnt;
  logic              r_d, r_rise, r_fall;
  logic              w_s, w_diff, w_take;
  assign w_s    = r_sync[STAGES-1];
  assign w_diff = w_s ^ r_d;
  // accept on the enabled sample that would bring the count up to FILT_CYCLES
  assign w_take = i_en & w_diff & (r_cnt == CW'(FILT_CYCLES - 1));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sync <= {STAGES{INIT}};
      r_cnt  <= '0;
      r_d    <= INIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= STAGES'({r_sync, i_d});
      r_cnt  <= (!w_diff || w_take) ? '0 : i_en ? r_cnt + CW'(1) : r_cnt;
      r_d    <= w_take ? w_s : r_d;
      r_rise <= w_take & w_s;
      r_fall <= w_take & ~w_s;
    end
  assign o_d    = r_d;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

// File: rtl/gpio_sync_filter.sv
// gpio_sync_filter: WIDTH-channel synchronise + debounce with edge pulses
// GPIO_SYNC_FILTER_STICKY_EN builds the sticky EVT flags; otherwise EVT is tied to 0.
module gpio_sync_filter
  import gpio_sync_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               STAGES      = DEF_STAGES,
  parameter int               FILT_CYCLES = DEF_FILT_CYCLES,
  parameter logic [WIDTH-1:0] INIT        = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d_in,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_evt_clr,
  output logic [WIDTH-1:0] o_d_out,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_evt
);
  logic [WIDTH-1:0] w_rise, w_fall;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    gpio_sync_filter_ch #(
      .STAGES     (STAGES),
      .FILT_CYCLES(FILT_CYCLES),
      .INIT       (INIT[i])
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_d    (i_d_in[i]),
      .i_en   (i_en),
      .o_d    (o_d_out[i]),
      .o_rise (w_rise[i]),
      .o_fall (w_fall[i])
    );
  end
  assign o_rise = w_rise;
  assign o_fall = w_fall;
`ifdef GPIO_SYNC_FILTER_STICKY_EN
  logic [WIDTH-1:0] r_evt;
  // set wins over clear when both land in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_evt <= '0;
    else          r_evt <= w_rise | w_fall | (r_evt & ~i_evt_clr);
  assign o_evt = r_evt;
`else
  logic w_unused_evt_clr;
  assign w_unused_evt_clr = ^i_evt_clr;
  assign o_evt = '0;
`endif
endmodule

// File: tb/tb_gpio_sync_filter.sv
// tb_gpio_sync_filter: scoreboard bench, default instance plus INIT=A5/STAGES=3/FILT_CYCLES=1 instance
`timescale 1ns/1ps
module tb_gpio_sync_filter;
  typedef struct packed {logic [7:0] dout, rise, fall, evt;} obs_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [7:0] d_in = 8'h00, evt_clr = 8'h00;
  logic [7:0] d0, r0, f0, e0, d1, r1, f1, e1;
  int stg[2] = '{2, 3};
  int flt[2] = '{4, 1};
  logic [7:0] ini[2] = '{8'h00, 8'hA5};
  obs_t st[2];
  int run[2][8];
  logic [7:0] pipe[2][4];
  obs_t q0[$], q1[$];
  int vectors = 0, miscompares = 0;
`ifdef GPIO_SYNC_FILTER_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  always #5 clk = ~clk;
  gpio_sync_filter dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_d_in(d_in), .i_en(en), .i_evt_clr(evt_clr),
    .o_d_out(d0), .o_rise(r0), .o_fall(f0), .o_evt(e0)
  );
  gpio_sync_filter #(.WIDTH(8), .STAGES(3), .FILT_CYCLES(1), .INIT(8'hA5)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_d_in(d_in), .i_en(en), .i_evt_clr(evt_clr),
    .o_d_out(d1), .o_rise(r1), .o_fall(f1), .o_evt(e1)
  );
  task automatic mdl_reset();
    for (int m = 0; m < 2; m++) begin
      st[m] = '{dout: ini[m], rise: 8'h00, fall: 8'h00, evt: 8'h00};
      for (int i = 0; i < 8; i++) run[m][i] = 0;
      for (int k = 0; k < 4; k++) pipe[m][k] = ini[m];
    end
  endtask
  // a level is accepted once it has been seen on flt consecutive enabled samples
  task automatic mdl_clock();
    for (int m = 0; m < 2; m++) begin
      obs_t n;
      logic [7:0] s;
      s = pipe[m][stg[m]-1];
      n = st[m];
      n.rise = 8'h00;
      n.fall = 8'h00;
      n.evt = STICKY ? (st[m].rise | st[m].fall | (st[m].evt & ~evt_clr)) : 8'h00;
      for (int i = 0; i < 8; i++)
        if (s[i] == st[m].dout[i]) run[m][i] = 0;
        else if (en) begin
          run[m][i]++;
          if (run[m][i] == flt[m]) begin
            n.dout[i] = s[i];
            n.rise[i] = s[i];
            n.fall[i] = ~s[i];
            run[m][i] = 0;
          end
        end
      for (int k = 3; k > 0; k--) pipe[m][k] = pipe[m][k-1];
      pipe[m][0] = d_in;
      st[m] = n;
    end
  endtask
  task automatic step(input logic [7:0] d, input logic e, input logic [7:0] c, input logic r);
    d_in = d;
    en = e;
    evt_clr = c;
    rst_n = r;
    if (!r) mdl_reset();
    else mdl_clock();
    q0.push_back(st[0]);
    q1.push_back(st[1]);
    @(negedge clk);
  endtask
  task automatic chk(input int m, input obs_t exp, input obs_t got);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL dut%0d t=%0t got dout=%h rise=%h fall=%h evt=%h, expected dout=%h rise=%h fall=%h evt=%h",
               m, $time, got.dout, got.rise, got.fall, got.evt, exp.dout, exp.rise, exp.fall, exp.evt);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) chk(0, q0.pop_front(), {d0, r0, f0, e0});
    if (q1.size() > 0) chk(1, q1.pop_front(), {d1, r1, f1, e1});
  end
  task automatic async_rst_chk();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({d0, r0, f0, e0, d1, r1, f1, e1} !== {8'h00, 24'h0, 8'hA5, 24'h0}) begin
      miscompares++;
      $display("FAIL async_reset got d0=%h r0=%h f0=%h e0=%h d1=%h r1=%h f1=%h e1=%h, expected d0=00 d1=a5 pulses/evt 00",
               d0, r0, f0, e0, d1, r1, f1, e1);
    end
  endtask
  initial begin
    logic [7:0] d;
    repeat (3) step(8'h00, 1'b1, 8'h00, 1'b0);
    repeat (3) step(8'h00, 1'b1, 8'h00, 1'b1);
    repeat (10) step(8'h01, 1'b1, 8'h00, 1'b1);
    repeat (3) step(8'h09, 1'b1, 8'h00, 1'b1);
    repeat (8) step(8'h01, 1'b1, 8'hFF, 1'b1);
    repeat (10) step(8'hFF, 1'b0, 8'h00, 1'b1);
    repeat (8) step(8'hFF, 1'b1, 8'h00, 1'b1);
    repeat (8) step(8'hDF, 1'b1, 8'h20, 1'b1);
    repeat (3) step(8'hDF, 1'b1, 8'h00, 1'b1);
    step(8'hDF, 1'b1, 8'h20, 1'b1);
    repeat (2) step(8'hDF, 1'b1, 8'h00, 1'b1);
    repeat (3) step(8'h00, 1'b1, 8'h00, 1'b1);
    async_rst_chk();
    step(8'h00, 1'b1, 8'h00, 1'b0);
    repeat (8) step(8'h00, 1'b1, 8'h00, 1'b1);
    d = 8'h00;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 5) == 0) d[i] = ~d[i];
      step(d, $urandom_range(0, 7) != 0, 8'($urandom) & 8'($urandom), 1'b1);
    end
    for (int k = 0; k < 5 && (q0.size() > 0 || q1.size() > 0); k++) @(negedge clk);
    if (q0.size() > 0 || q1.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gpio_sync_filter.md
GPIO_SYNC_FILTER -- requirements
Module: gpio_sync_filter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of independent input channels.
REQ-002 The block SHALL have parameter STAGES, default 2, legal range 1..4, giving the synchroniser register depth per channel.
REQ-003 The block SHALL have parameter FILT_CYCLES, default 4, legal range 1..255, giving the number of consecutive stable samples required to accept a new level.
REQ-004 The block SHALL have parameter INIT, WIDTH bits, default all 0, giving the reset value of every per-channel register and of D_OUT.
REQ-005 CLK  input  1  single clock; all state on posedge CLK.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 D_IN  input  WIDTH  asynchronous external levels, unrelated to CLK.
REQ-008 EN  input  1  sample enable for the filter stage.
REQ-009 EVT_CLR  input  WIDTH  per-channel clear of sticky event flags.
REQ-010 D_OUT  output  WIDTH  filtered, synchronised level.
REQ-011 RISE  output  WIDTH  one-cycle pulse on an accepted 0->1 transition.
REQ-012 FALL  output  WIDTH  one-cycle pulse on an accepted 1->0 transition.
REQ-013 EVT  output  WIDTH  sticky flag: an edge was accepted since the last clear.

Function
REQ-014 Each channel SHALL pass D_IN[i] through a STAGES-deep register chain clocked every cycle, independent of EN; S[i] is the last stage.
REQ-015 Each channel SHALL hold a counter CNT of width ceil(log2(FILT_CYCLES+1)) that resets to 0 whenever S[i]==D_OUT[i].
REQ-016 While EN=1 and S[i]!=D_OUT[i], CNT SHALL increment; on the cycle CNT would reach FILT_CYCLES, D_OUT[i] SHALL take S[i] and CNT SHALL clear.
REQ-017 While EN=0, CNT and D_OUT SHALL hold; the synchroniser SHALL keep running.
REQ-018 With FILT_CYCLES=1, D_OUT[i] SHALL follow S[i] one cycle later on every EN=1 cycle.
REQ-019 Latency from a stable D_IN change to D_OUT change SHALL be exactly STAGES+FILT_CYCLES cycles with EN held 1.
REQ-020 A S[i] glitch shorter than FILT_CYCLES cycles SHALL leave D_OUT, RISE, FALL and EVT unchanged.
REQ-021 RISE[i] or FALL[i] SHALL be registered and asserted for exactly the one cycle in which D_OUT[i] first shows the new value.
REQ-022 EVT[i] SHALL set in the cycle after RISE[i]|FALL[i], clear in the cycle after EVT_CLR[i]=1; simultaneous set and clear SHALL leave EVT[i]=1.
REQ-023 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each be reported.

Reset
REQ-024 RST_N=0 SHALL immediately set all synchroniser stages and D_OUT to INIT, CNT to 0, RISE, FALL and EVT to 0, regardless of CLK.
REQ-025 Reset asserted mid-filter SHALL discard any partial count; no RISE/FALL SHALL be generated by reset assertion or release.
REQ-026 The first post-reset edge SHALL be reported only if the filtered level differs from INIT.

Configuration
REQ-027 With macro GPIO_SYNC_FILTER_STICKY_EN defined, EVT registers and EVT_CLR logic SHALL be built per REQ-022.
REQ-028 Without GPIO_SYNC_FILTER_STICKY_EN, EVT SHALL be constant 0, EVT_CLR SHALL be ignored, and no EVT registers SHALL exist.

Structure
REQ-029 Shared package gpio_sync_pkg SHALL hold default constants (STAGES, FILT_CYCLES) and the counter-width function.
REQ-030 Per-channel logic SHALL be sub-module gpio_sync_filter_ch, instantiated WIDTH times by a generate loop.
REQ-031 Synchroniser registers SHALL carry no logic between stages.

Verification
REQ-032 WIDTH=8, STAGES=2, FILT_CYCLES=4, EN=1: D_IN[0] 0->1 held -> D_OUT[0]=1 and RISE[0]=1 exactly 6 cycles later, RISE one cycle only.
REQ-033 Same config: D_IN[3] high for 3 cycles then low -> D_OUT, RISE, FALL, EVT stay 0.
REQ-034 D_IN=8'hFF held, EN=0 for 10 cycles then 1 -> D_OUT stays 0 during EN=0, becomes 8'hFF 4 cycles after EN rises.
REQ-035 STICKY_EN defined: edge on channel 5 with EVT_CLR[5]=1 in the set cycle -> EVT[5]=1; next EVT_CLR[5] pulse -> EVT[5]=0.
REQ-036 INIT=8'hA5, RST_N pulsed low mid-count -> D_OUT=8'hA5, CNT=0, no RISE/FALL across release.
REQ-037 STICKY_EN undefined: repeated edges plus EVT_CLR activity -> EVT remains 8'h00.
